// File: rtl/mul_div_unit.sv
// rtl/mul_div_unit.sv - multi-cycle radix-2 multiply/divide unit with HI/LO registers
module mul_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             CLOCK,
  input  logic             RESET,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             flush,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t state_q, state_d;
  logic   accept, step, commit, direct_ok;

  logic [CW-1:0]      cnt_q;
  logic               is_div_q, neg_q_q, neg_r_q, div_zero_q;
  logic [WIDTH-1:0]   b_mag_q;
  // Shared accumulator: multiply keeps {partial product, multiplier},
  // divide keeps {partial remainder, dividend/quotient bits}.
  logic [2*WIDTH-1:0] acc_q;

  // Operand magnitudes and result sign flags for the op being issued
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  assign a_neg = op[0] & src_a[WIDTH-1];
  assign b_neg = op[0] & src_b[WIDTH-1];
  assign a_mag = a_neg ? -src_a : src_a;
  assign b_mag = b_neg ? -src_b : src_b;

  // One shift-add step: add the multiplicand when the current multiplier bit is set
  logic [WIDTH:0]       mul_sum;
  logic [2*WIDTH-1:0]   mul_next;
  assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, b_mag_q} : '0);
  assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

  // One restoring step: the difference fits in WIDTH bits whenever it is kept
  logic [WIDTH:0]       div_shift;
  logic [WIDTH-1:0]     div_sub;
  logic                 div_ok;
  logic [2*WIDTH-1:0]   div_next;
  assign div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
  assign div_ok    = div_shift >= {1'b0, b_mag_q};
  assign div_sub   = div_shift[WIDTH-1:0] - b_mag_q;
  assign div_next  = div_ok ? {div_sub, acc_q[WIDTH-2:0], 1'b1}
                            : {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};

  // Sign correction; divide-by-zero leaves the dividend in the remainder naturally
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quot, rem, res_hi, res_lo;
  assign prod   = neg_q_q ? -acc_q : acc_q;
  assign quot   = neg_q_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
  assign rem    = neg_r_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
  assign res_hi = is_div_q ? rem : prod[2*WIDTH-1:WIDTH];
  assign res_lo = is_div_q ? (div_zero_q ? '1 : quot) : prod[WIDTH-1:0];

  // State register
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next state and control strobes; flush overrides everything
  always_comb begin
    state_d   = state_q;
    accept    = 1'b0;
    step      = 1'b0;
    commit    = 1'b0;
    direct_ok = 1'b0;
    busy      = (state_q != IDLE);
    unique case (state_q)
      IDLE: begin
        direct_ok = ~start;
        if (start) begin
          state_d = RUN;
          accept  = 1'b1;
        end
      end
      RUN: begin
        step = 1'b1;
        if (cnt_q == LAST) state_d = FIX;
      end
      FIX: begin
        commit  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (flush) begin
      state_d = IDLE;
      accept  = 1'b0;
      step    = 1'b0;
      commit  = 1'b0;
    end
  end

  // Iteration datapath: load on accept, one radix-2 step per RUN cycle
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      cnt_q      <= '0;
      is_div_q   <= 1'b0;
      neg_q_q    <= 1'b0;
      neg_r_q    <= 1'b0;
      div_zero_q <= 1'b0;
      b_mag_q    <= '0;
      acc_q      <= '0;
    end else if (accept) begin
      cnt_q      <= '0;
      is_div_q   <= op[1];
      neg_q_q    <= a_neg ^ b_neg;
      neg_r_q    <= a_neg;
      div_zero_q <= (src_b == '0);
      b_mag_q    <= b_mag;
      acc_q      <= {{WIDTH{1'b0}}, a_mag};
    end else if (step) begin
      cnt_q <= cnt_q + CW'(1);
      acc_q <= is_div_q ? div_next : mul_next;
    end
  end

  // Architectural HI/LO: result commit, or direct writes when idle and not starting
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      hi   <= '0;
      lo   <= '0;
      done <= 1'b0;
    end else begin
      done <= commit;
      if (commit) begin
        hi <= res_hi;
        lo <= res_lo;
      end else if (direct_ok) begin
        if (hi_we) hi <= wdata;
        if (lo_we) lo <= wdata;
      end
    end
  end

endmodule

// File: doc/mul_div_unit.md
# mul_div_unit

Parametrised multi-cycle multiply/divide unit with architectural HI/LO registers, attached to the execute stage of the pipelined CPU. It accepts MULT/MULTU/DIV/DIVU operations from EX, iterates one bit per cycle, and reports `busy` so the hazard logic can stall any later HI/LO access. It also supports direct HI/LO writes (MTHI/MTLO) and pipeline flush. Datapath width is a parameter, so the same block serves the 32-bit core and narrower test builds.

## Interface
- `WIDTH`, 32: operand width; HI, LO and both sources are `WIDTH` bits; minimum 4.
- `CLOCK`  in  1  single clock, rising-edge.
- `RESET`  in  1  asynchronous, active-high reset.
- `start`  in  1  request an operation; sampled on `CLOCK` rising edge.
- `op`  in  2  operation: 0=MULTU, 1=MULT, 2=DIVU, 3=DIV.
- `src_a`  in  WIDTH  multiplicand / dividend (rs).
- `src_b`  in  WIDTH  multiplier / divisor (rt).
- `flush`  in  1  abort the in-flight operation.
- `hi_we`, `lo_we`  in  1 each  direct write of `wdata` into HI / LO.
- `wdata`  in  WIDTH  data for `hi_we`/`lo_we`.
- `busy`  out  1  operation in progress.
- `done`  out  1  one-cycle pulse; HI/LO hold the new result.
- `hi`, `lo`  out  WIDTH each  architectural HI/LO register contents.

## Operation
- FSM states: IDLE, RUN, FIX.
- IDLE + `start` (and no `flush`): latch `op`; latch operand magnitudes (two's-complement negate when signed op and MSB=1); latch result sign flags; clear the iteration counter; go to RUN.
- RUN: `WIDTH` iterations, one per cycle.
  - Multiply: radix-2 shift-add into a 2·WIDTH accumulator.
  - Divide: radix-2 restoring, producing a quotient and remainder.
  - After the iteration with counter = WIDTH-1, go to FIX.
- FIX: apply sign correction, write HI/LO, pulse `done`, go to IDLE.
  - Multiply: {HI,LO} = full 2·WIDTH product. MULT product is negated when the operand signs differ.
  - Divide: LO = quotient, HI = remainder.
  - DIV quotient truncates toward zero. The remainder takes the sign of the dividend.
  - Divisor 0 (DIVU or DIV): HI = `src_a` as issued, LO = all ones. No trap; normal latency.
  - DIV with most-negative / -1: LO = most-negative, HI = 0 (wraps).
- `busy` = (state != IDLE).
- `start` while busy: ignored; no queuing.
- `flush`: from any state go to IDLE. HI/LO unchanged, no `done`. Priority `flush` > `start`.
- `hi_we`/`lo_we`: take effect only in IDLE without `start`; otherwise dropped. Both may be asserted together. Never alter an in-flight result.
- Reset (any time, including mid-operation): state IDLE, HI=0, LO=0, `busy`=0, `done`=0, counter=0, internal datapath cleared.

## Timing
- Start accepted at edge k. `busy`=1 for cycles k+1 … k+WIDTH+1 (WIDTH RUN cycles + 1 FIX cycle).
- Edge k+WIDTH+1: HI/LO updated, `busy`→0, `done`→1 for exactly one cycle.
- Latency: WIDTH+1 cycles from accepting edge to result edge. For WIDTH=32, the result appears 33 edges after start.
- The `done` cycle is IDLE: a new `start` is accepted in that same cycle (back-to-back issue, no bubble).
- `hi`/`lo` are registered outputs. Direct writes are visible the cycle after the write edge.
- `flush` asserted in cycle c: `busy`=0 from c+1.
- `RESET` asserts outputs asynchronously, with no clock edge needed.

## Test plan
- MULTU 0xFFFFFFFF × 0xFFFFFFFF (WIDTH=32) -> after 33 edges HI=0xFFFFFFFE, LO=0x00000001, `done` high one cycle, `busy` high exactly 33 cycles.
- MULT -3 × 5, then DIV -7 / 2 issued in the `done` cycle -> first result HI=0xFFFFFFFF, LO=0xFFFFFFF1; second HI=0xFFFFFFFF, LO=0xFFFFFFFD; no idle gap between operations.
- DIVU 100 / 0 and DIV 0x80000000 / 0xFFFFFFFF -> HI=0x00000064, LO=0xFFFFFFFF; then HI=0, LO=0x80000000.
- Preload HI=0xAAAA5555 via `hi_we`. Start DIVU and assert `flush` in RUN cycle 10 -> `busy` drops the next cycle, no `done`, HI still 0xAAAA5555. A `hi_we` or `start` asserted while busy has no effect.
- Assert RESET asynchronously mid-RUN (between edges) -> `busy`, `done`, HI, LO go to 0 immediately. A subsequent MULTU 7×6 gives LO=42, HI=0.
- WIDTH=8 build, DIV 0x80 / 0x03 -> LO=0xD6 (-42), HI=0xFE (-2), result 9 edges after start.
